// File: rtl/kyber_encrypt_sequencer.sv
// Baby Kyber encryption sequencer: drives one shared polynomial multiplier through the six
// products of an encryption, folds product pairs with noise and message, and emits (u, v) mod Q.
module kyber_encrypt_sequencer #(
  parameter int Q       = 17,
  parameter int QHALF   = 9,
  parameter int N       = 4,
  parameter int K       = 2,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N-1:0]     msg,
  input  logic [K*N*W-1:0] e1_in,
  input  logic [N*W-1:0]   e2_in,
  output logic             mul_start,
  output logic [2:0]       mul_sel,
  input  logic             mul_done,
  input  logic [N*W-1:0]   mul_result,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [K*N*W-1:0] u_out,
  output logic [N*W-1:0]   v_out,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  localparam int SW  = W + 3;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic signed [SW-1:0] QS = SW'(Q);
  localparam logic [SW-1:0]        QH = SW'(QHALF);

  // Non-negative residue for either sign of x.
  function automatic logic [W-1:0] mod_q(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] r;
    r = x % QS;
    if (r[SW-1]) r = r + QS;
    return W'(r);
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       p_q, p_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [N-1:0]     msg_q;
  logic [K*N*W-1:0] e1_q;
  logic [N*W-1:0]   e2_q;
  logic [K*N*W-1:0] u_q;
  logic [N*W-1:0]   v_q;
  logic [K*N*W-1:0] u_new;
  logic [N*W-1:0]   v_new;
  logic             accept;
  logic             take;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          accept  = 1'b1;
          p_d     = 3'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          take = 1'b1;
          if (p_q == 3'd5) begin
            state_d = OUT;
          end else begin
            p_d     = p_q + 3'd1;
            state_d = ISSUE;
          end
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      OUT: begin
        if (ct_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= 3'd0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      msg_q     <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      if (accept) begin
        msg_q <= msg;
        e1_q  <= e1_in;
        e2_q  <= e2_in;
      end
    end
  end

  // Per-coefficient accumulator and the candidate reduced values for u rows and v.
  for (genvar gi = 0; gi < N; gi++) begin : g_coef
    logic [W:0]    acc_q;
    logic [W:0]    res_ext;
    logic [W:0]    sum;
    logic [SW-1:0] acc_mod;
    logic [SW-1:0] e2_ext;
    logic [SW-1:0] msg_term;

    assign res_ext  = {mul_result[gi*W+W-1], mul_result[gi*W +: W]};
    assign sum      = acc_q + res_ext;
    assign acc_mod  = SW'(mod_q({{2{sum[W]}}, sum}));
    assign e2_ext   = {{3{e2_q[gi*W+W-1]}}, e2_q[gi*W +: W]};
    assign msg_term = msg_q[N-1-gi] ? QH : '0;
    assign v_new[gi*W +: W] = mod_q(acc_mod + e2_ext - msg_term);

    for (genvar gk = 0; gk < K; gk++) begin : g_row
      localparam int B = (gk*N + gi)*W;
      assign u_new[B +: W] = mod_q(acc_mod + {{3{e1_q[B+W-1]}}, e1_q[B +: W]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else if (take) acc_q <= p_q[0] ? sum : res_ext;
    end
  end

  // Odd products close a pair: p=1 -> u row 0, p=3 -> u row 1, p=5 -> v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= '0;
      v_q <= '0;
    end else if (take && p_q[0]) begin
      if (p_q[2]) v_q <= v_new;
      else if (p_q[1]) u_q[N*W +: N*W] <= u_new[N*W +: N*W];
      else u_q[0 +: N*W] <= u_new[0 +: N*W];
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mul_start   = (state_q == ISSUE);
  assign mul_sel     = p_q;
  assign ct_valid    = (state_q == OUT);
  assign timeout_err = timeout_q;
  assign u_out       = u_q;
  assign v_out       = v_q;

endmodule

// File: tb/tb_kyber_encrypt_sequencer.sv
// Scoreboard bench for kyber_encrypt_sequencer with a behavioural shared multiplier.
module tb_kyber_encrypt_sequencer;

  localparam int N = 4;
  localparam int K = 2;
  localparam int W = 32;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [N-1:0]     msg;
  logic [K*N*W-1:0] e1_in;
  logic [N*W-1:0]   e2_in;
  logic             mul_start;
  logic [2:0]       mul_sel;
  logic             mul_done;
  logic [N*W-1:0]   mul_result;
  logic             ct_valid;
  logic             ct_ready;
  logic [K*N*W-1:0] u_out;
  logic [N*W-1:0]   v_out;
  logic             busy;
  logic             timeout_err;

  kyber_encrypt_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .msg(msg), .e1_in(e1_in), .e2_in(e2_in), .mul_start(mul_start), .mul_sel(mul_sel),
    .mul_done(mul_done), .mul_result(mul_result), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .u_out(u_out), .v_out(v_out), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [K*N*W-1:0] u;
    logic [N*W-1:0]   v;
  } ct_t;

  ct_t exp_q[$];
  ct_t last_exp;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  res_tab[6][4];
  int  mul_lat = 1;
  bit  mul_en = 1;
  bit  inject = 0;
  int  sel_log[$];
  int  e1v[8];
  int  e2v[4];
  int  ue[8];
  int  ve[4];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Shared multiplier: answers L cycles after mul_start with the table row for mul_sel.
  initial begin
    int cnt;
    int sel;
    cnt = 0;
    sel = 0;
    mul_done = 0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      mul_done = 0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mul_done = 1;
            for (int j = 0; j < N; j++) mul_result[j*W +: W] = res_tab[sel][j];
          end
        end
        if (mul_start) begin
          sel = int'(mul_sel);
          sel_log.push_back(sel);
          if (mul_en) cnt = mul_lat;
        end
      end
      if (inject) begin
        inject = 0;
        mul_done = 1;
        mul_result = {N{32'd5}};
      end
    end
  end

  // Monitor: every ct handshake pops one expected ciphertext.
  initial begin
    ct_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && ct_valid && ct_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ct_unexpected u=%0h v=%0h want=no_output", u_out, v_out);
        end else begin
          e = exp_q.pop_front();
          chk("ct_u", u_out, e.u);
          chk("ct_v", v_out, e.v);
          $display("ct handshake at cycle %0d u=%0h v=%0h", cyc, u_out, v_out);
        end
      end
    end
  end

  function automatic ct_t make_exp();
    ct_t c;
    c = '0;
    for (int i = 0; i < 8; i++) c.u[i*W +: W] = ue[i];
    for (int j = 0; j < 4; j++) c.v[j*W +: W] = ve[j];
    return c;
  endfunction

  task automatic apply_inputs(input logic [3:0] m);
    msg = m;
    for (int i = 0; i < 8; i++) e1_in[i*W +: W] = e1v[i];
    for (int j = 0; j < 4; j++) e2_in[j*W +: W] = e2v[j];
  endtask

  task automatic push_exp();
    last_exp = make_exp();
    exp_q.push_back(last_exp);
  endtask

  task automatic accept_job(input bit keep, output int t0);
    start_valid = 1;
    for (int k = 0; k < 100 && !start_ready; k++) @(negedge clk);
    if (!start_ready) begin
      total++;
      bad++;
      $display("FAIL accept_wait got=start_ready_0 want=start_ready_1");
    end
    t0 = cyc;
    @(negedge clk);
    if (!keep) start_valid = 0;
  endtask

  task automatic wait_ct(input int t0, input int want_lat);
    for (int k = 0; k < 300 && !ct_valid; k++) @(negedge clk);
    chk("latency", cyc - t0, want_lat);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_mul_sel"}, mul_sel, 0);
    chk({tag, "_ct_valid"}, ct_valid, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_u_out"}, u_out, 0);
    chk({tag, "_v_out"}, v_out, 0);
  endtask

  task automatic load_table4();
    res_tab = '{'{1, 2, 3, 4}, '{10, 20, 30, 40}, '{-1, -2, -3, -4},
                '{0, 0, 0, 100}, '{5, 5, 5, 5}, '{-100, 0, 7, 1}};
    e1v = '{0, 1, 2, 3, -5, 0, 5, 16};
    e2v = '{1, -1, 3, 0};
  endtask

  initial begin
    int t0;
    int first_to;
    int n_to;
    int n_ct;
    rst_n = 0;
    start_valid = 0;
    ct_ready = 1;
    msg = '0;
    e1_in = '0;
    e2_in = '0;
    res_tab = '{default: '{default: 0}};
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1;
    @(negedge clk);

    // Zero products, message bit 0 lands in v[3].
    e1v = '{default: 0};
    e2v = '{default: 0};
    ue = '{default: 0};
    ve = '{0, 0, 0, 8};
    apply_inputs(4'b0001);
    push_exp();
    sel_log.delete();
    accept_job(0, t0);
    wait_ct(t0, 13);
    chk("mul_start_count", sel_log.size(), 6);
    for (int k = 0; k < 6 && k < sel_log.size(); k++) chk("mul_sel_seq", sel_log[k], k);

    // Constant 20 products, negative e1.
    res_tab = '{default: '{default: 20}};
    e1v = '{default: -1};
    e2v = '{default: 2};
    ue = '{default: 5};
    ve = '{default: 8};
    apply_inputs(4'b0000);
    push_exp();
    accept_job(0, t0);
    wait_ct(t0, 13);

    // Negative pair sum -35.
    res_tab = '{'{-30, -30, -30, -30}, '{-5, -5, -5, -5}, '{-30, -30, -30, -30},
                '{-5, -5, -5, -5}, '{-30, -30, -30, -30}, '{-5, -5, -5, -5}};
    e1v = '{default: 1};
    e2v = '{default: 0};
    ue = '{default: 0};
    ve = '{default: 7};
    apply_inputs(4'b1111);
    push_exp();
    accept_job(0, t0);
    wait_ct(t0, 13);

    // Distinct products per index and coefficient, multiplier latency 3.
    load_table4();
    ue = '{11, 6, 1, 13, 11, 15, 2, 10};
    ve = '{16, 12, 15, 6};
    apply_inputs(4'b1100);
    push_exp();
    mul_lat = 3;
    accept_job(0, t0);
    wait_ct(t0, 25);

    // Extreme 32-bit values, multiplier latency 2.
    res_tab = '{default: '{default: 2147483647}};
    e1v = '{default: int'(32'h80000000)};
    e2v = '{default: 2147483647};
    ue = '{default: 7};
    ve = '{15, 7, 15, 7};
    apply_inputs(4'b1010);
    push_exp();
    mul_lat = 2;
    accept_job(0, t0);
    wait_ct(t0, 19);

    // Back-pressure with start_valid held high: two jobs with identical inputs.
    mul_lat = 1;
    res_tab = '{default: '{default: 20}};
    e1v = '{default: -1};
    e2v = '{default: 2};
    ue = '{default: 5};
    ve = '{default: 8};
    apply_inputs(4'b0000);
    push_exp();
    push_exp();
    ct_ready = 0;
    accept_job(1, t0);
    for (int k = 0; k < 300 && !ct_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_ct_valid", ct_valid, 1);
      chk("hold_u", u_out, last_exp.u);
      chk("hold_v", v_out, last_exp.v);
      chk("hold_start_ready", start_ready, 0);
      @(negedge clk);
    end
    ct_ready = 1;
    @(negedge clk);
    chk("post_hs_ct_valid", ct_valid, 0);
    chk("post_hs_start_ready", start_ready, 1);
    t0 = cyc;
    @(negedge clk);
    start_valid = 0;
    chk("reaccept_busy", busy, 1);
    chk("reaccept_mul_start", mul_start, 1);
    wait_ct(t0, 13);

    // Silent multiplier: watchdog abort after 8 WAIT cycles.
    mul_en = 0;
    apply_inputs(4'b0101);
    accept_job(0, t0);
    first_to = -1;
    n_to = 0;
    n_ct = 0;
    for (int k = 0; k < 30; k++) begin
      if (timeout_err) begin
        n_to++;
        if (first_to < 0) begin
          first_to = cyc - t0;
          chk("to_start_ready", start_ready, 1);
          chk("to_busy", busy, 0);
        end
      end
      if (ct_valid) n_ct++;
      @(negedge clk);
    end
    chk("to_cycle", first_to, 10);
    chk("to_pulses", n_to, 1);
    chk("to_ct_valid_count", n_ct, 0);
    chk("to_u_kept", u_out, last_exp.u);
    chk("to_v_kept", v_out, last_exp.v);
    mul_en = 1;

    // Reset during WAIT of p=3, then a stale done after release.
    load_table4();
    apply_inputs(4'b1100);
    mul_lat = 4;
    accept_job(0, t0);
    for (int k = 0; k < 200 && !(mul_sel == 3'd3 && busy && !mul_start); k++) @(negedge clk);
    chk("midrst_reached_p3", mul_sel, 3);
    rst_n = 0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    inject = 1;
    repeat (3) @(negedge clk);
    chk_reset_vals("stale");

    // Fresh job after reset.
    mul_lat = 1;
    res_tab = '{'{-30, -30, -30, -30}, '{-5, -5, -5, -5}, '{-30, -30, -30, -30},
                '{-5, -5, -5, -5}, '{-30, -30, -30, -30}, '{-5, -5, -5, -5}};
    e1v = '{default: 1};
    e2v = '{default: 0};
    ue = '{default: 0};
    ve = '{default: 7};
    apply_inputs(4'b1111);
    push_exp();
    accept_job(0, t0);
    wait_ct(t0, 13);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
